// File: rtl/dsp_seq_divider.sv
// Radix-2 restoring divider (one quotient bit per cycle, MSB first) with valid/ready handshakes on input and output.
// Define DSP_DIV_SIGNED_EN to get two's-complement operands: the operands are converted to magnitudes and the result is re-signed.
module dsp_seq_divider #(
   parameter int NW = 48,
   parameter int DW = 18
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [NW-1:0] N,
   input  logic [DW-1:0] D,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [NW-1:0] Q,
   output logic [DW-1:0] R,
   output logic          div_by_zero
);

   localparam int CW = (NW > 1) ? $clog2(NW) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state, state_nxt;
   logic [NW-1:0] nq;        // dividend bits shift out at the top, quotient bits shift in at the bottom
   logic [DW:0]   rem;
   logic [DW-1:0] dvs;
   logic [CW-1:0] cnt;
   logic          neg_q, neg_r;

   logic          accept;
   logic          n_neg, d_neg;
   logic [NW-1:0] n_mag;
   logic [DW-1:0] d_mag;
   logic [DW:0]   rem_sh, trial, rem_nxt;
   logic          qbit;
   logic [NW-1:0] nq_nxt, q_res;
   logic [DW-1:0] r_res;

`ifdef DSP_DIV_SIGNED_EN
   assign n_neg = N[NW-1];
   assign d_neg = D[DW-1];
   assign n_mag = n_neg ? -N : N;
   assign d_mag = d_neg ? -D : D;
   assign q_res = neg_q ? -nq_nxt : nq_nxt;
   assign r_res = neg_r ? -rem_nxt[DW-1:0] : rem_nxt[DW-1:0];
`else
   assign n_neg = 1'b0;
   assign d_neg = 1'b0;
   assign n_mag = N;
   assign d_mag = D;
   assign q_res = nq_nxt;
   assign r_res = rem_nxt[DW-1:0];
`endif

   assign accept = in_valid && in_ready;

   // The partial remainder stays below the divisor, so bit DW of trial is a clean borrow flag.
   assign rem_sh  = {rem[DW-1:0], nq[NW-1]};
   assign trial   = rem_sh - {1'b0, dvs};
   assign qbit    = ~trial[DW];
   assign rem_nxt = qbit ? trial : rem_sh;
   assign nq_nxt  = {nq[NW-2:0], qbit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid && rst_n) begin
               state_nxt = (D == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt == '0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nq          <= '0;
         rem         <= '0;
         dvs         <= '0;
         cnt         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         Q           <= '0;
         R           <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (D == '0) begin
                     Q           <= '1;
                     R           <= N[DW-1:0];
                     div_by_zero <= 1'b1;
                  end else begin
                     nq    <= n_mag;
                     dvs   <= d_mag;
                     rem   <= '0;
                     cnt   <= CW'(NW - 1);
                     neg_q <= n_neg ^ d_neg;
                     neg_r <= n_neg;
                  end
               end
            end
            CALC: begin
               nq  <= nq_nxt;
               rem <= rem_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  Q           <= q_res;
                  R           <= r_res;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dsp_seq_divider.sv
// Scoreboard bench for dsp_seq_divider: expected results are queued at accept and compared when out_valid appears.
module tb_dsp_seq_divider;

   localparam int NW = 48;
   localparam int DW = 18;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [NW-1:0] n_in;
   logic [DW-1:0] d_in;
   logic          out_valid;
   logic          out_ready;
   logic [NW-1:0] q_out;
   logic [DW-1:0] r_out;
   logic          dbz;

   typedef struct {
      logic [NW-1:0] q;
      logic [DW-1:0] r;
      logic          dbz;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   dsp_seq_divider #(.NW(NW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .N(n_in), .D(d_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .Q(q_out), .R(r_out), .div_by_zero(dbz)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [NW-1:0] n, input logic [DW-1:0] d);
      exp_t   e;
      longint ns, ds;
      ns = 0;
      ds = 0;
      if (d == '0) begin
         e.q   = '1;
         e.r   = n[DW-1:0];
         e.dbz = 1'b1;
      end else begin
`ifdef DSP_DIV_SIGNED_EN
         ns  = longint'($signed(n));
         ds  = longint'($signed(d));
         e.q = NW'(ns / ds);
         e.r = DW'(ns % ds);
`else
         ns  = longint'(n);
         ds  = longint'(d);
         e.q = NW'(ns / ds);
         e.r = DW'(ns % ds);
`endif
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Drives operands until accepted, queues the expected result, then scrambles the operand bus.
   task automatic accept_op(input logic [NW-1:0] n, input logic [DW-1:0] d, output bit ok);
      logic rdy;
      ok       = 1'b0;
      n_in     = n;
      d_in     = d;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      n_in     = {$urandom, $urandom};
      d_in     = DW'($urandom);
      checks++;
      if (ok) sb.push_back(model(n, d));
      else begin
         failures++;
         $display("FAIL accept_timeout got=in_ready_low exp=accept n=%h d=%h", n, d);
      end
   endtask

   // Latency in cycles: 1 means out_valid is already high right after the accept edge.
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_in      = '0;
      d_in      = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++;
      if (out_valid !== 1'b0 || dbz !== 1'b0) begin
         failures++; $display("FAIL reset_flags got=out_valid:%b dbz:%b exp=0,0", out_valid, dbz);
      end
      checks++;
      if (q_out !== '0 || r_out !== '0) begin
         failures++; $display("FAIL reset_qr got=%h/%h exp=0/0", q_out, r_out);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
   endtask

   // Accepts one operation with out_ready high and checks latency, result and the output handshake.
   task automatic test_op(input string name, input logic [NW-1:0] n, input logic [DW-1:0] d);
      bit   ok;
      int   lat;
      int   exp_lat;
      exp_t e;
      out_ready = 1'b1;
      accept_op(n, d, ok);
      if (!ok) return;
      exp_lat = (d == '0) ? 1 : NW + 1;
      wait_out(lat);
      checks++;
      if (lat !== exp_lat) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
      if (!out_valid) return;
      e = sb.pop_front();
      checks++;
      if (q_out !== e.q || r_out !== e.r || dbz !== e.dbz) begin
         failures++;
         $display("FAIL %s_result got=q:%h r:%h dbz:%b exp=q:%h r:%h dbz:%b", name, q_out, r_out, dbz, e.q, e.r, e.dbz);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_out_valid_drop got=%b exp=0", name, out_valid); end
   endtask

   task automatic test_basic;
      test_op("basic_100_7", 48'd100, 18'd7);
      test_op("max_operands", {NW{1'b1}}, {DW{1'b1}});
      test_op("n_less_than_d", 48'd5, 18'd9);
      test_op("divide_by_one", 48'hABCD_1234_5678, 18'd1);
   endtask

   task automatic test_div_by_zero;
      test_op("div_by_zero", 48'h123, 18'd0);
   endtask

   task automatic test_backpressure;
      bit   ok;
      int   lat;
      exp_t e;
      out_ready = 1'b0;
      accept_op(48'd1000, 18'd3, ok);
      if (!ok) return;
      wait_out(lat);
      checks++;
      if (lat !== NW + 1) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, NW + 1); end
      n_in     = 48'd555;
      d_in     = 18'd5;
      in_valid = 1'b1;
      e        = sb[0];
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (q_out !== e.q || r_out !== e.r || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got=q:%h r:%h in_ready:%b out_valid:%b exp=q:%h r:%h 0 1",
                     i, q_out, r_out, in_ready, out_valid, e.q, e.r);
         end
      end
      void'(sb.pop_front());
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", out_valid); end
      test_op("bp_next_op", 48'd555, 18'd5);
   endtask

   task automatic test_reset_mid_calc;
      bit ok;
      out_ready = 1'b1;
      accept_op(48'd12345, 18'd17, ok);
      if (!ok) return;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      void'(sb.pop_front());
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || q_out !== '0 || r_out !== '0) begin
         failures++;
         $display("FAIL mid_reset_clear got=ov:%b ir:%b q:%h r:%h exp=0 0 0 0", out_valid, in_ready, q_out, r_out);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL mid_reset_release got=ir:%b ov:%b exp=1 0", in_ready, out_valid);
      end
      test_op("after_reset_81_9", 48'd81, 18'd9);
   endtask

   task automatic test_back_to_back;
      logic [NW-1:0] n;
      logic [DW-1:0] d;
      for (int i = 0; i < 8; i++) begin
         n = {$urandom, $urandom};
         if (i % 2 == 1) n = NW'($urandom_range(0, 5000));
         d = DW'($urandom_range(1, (1 << DW) - 1));
         if (i == 3) d = DW'($urandom_range(1, 15));
         test_op("back_to_back", n, d);
      end
   endtask

`ifdef DSP_DIV_SIGNED_EN
   task automatic test_signed;
      logic [NW-1:0] most_neg;
      most_neg = {1'b1, {(NW-1){1'b0}}};
      test_op("signed_neg_n", -48'sd100, 18'd7);
      test_op("signed_neg_d", 48'd100, -18'sd7);
      test_op("signed_overflow", most_neg, {DW{1'b1}});
      test_op("signed_both_neg", -48'sd81, -18'sd9);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_div_by_zero();
      test_backpressure();
      test_reset_mid_calc();
      test_back_to_back();
`ifdef DSP_DIV_SIGNED_EN
      test_signed();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
